// File: rtl/hdu_pkg.sv
// Shared definitions for the load-use hazard scoreboard: register-file sizing,
// pend-counter width and the packed source-index slice helper.
`ifndef HDU_SRC
`define HDU_SRC(vec, i, aw) vec[(i)*(aw) +: (aw)]
`endif

package hdu_pkg;

   localparam int unsigned REG_AW_DEF   = 3;
   localparam int unsigned NUM_REGS_DEF = 2 ** REG_AW_DEF;

   // Counter must hold LOAD_LAT-1; never narrower than one bit.
   function automatic int unsigned pend_cnt_w(input int unsigned lat);
      return (lat < 2) ? 1 : $clog2(lat + 1);
   endfunction

endpackage

// File: rtl/hdu_pend_ctr.sv
// Per-register pending-load down-counter: a reload sets the remaining latency,
// otherwise it counts down to zero and stops there.
module hdu_pend_ctr #(
   parameter int unsigned W = 1
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic         dec_i,
   input  logic [W-1:0] reload_i,
   output logic [W-1:0] count_o,
   output logic         nonzero_o
);

   logic [W-1:0] count_d, count_q;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = reload_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o   = count_q;
   assign nonzero_o = (count_q != '0);

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Decode-stage load-use hazard unit: stalls PC/F_D and bubbles D_E while any
// used source (or optionally the destination) waits on an in-flight load.
module hazard_scoreboard_unit
   import hdu_pkg::*;
#(
   parameter int unsigned REG_AW    = REG_AW_DEF,
   parameter int unsigned NUM_SRC   = 2,
   parameter int unsigned LOAD_LAT  = 1,
   parameter bit          DST_CHECK = 1'b1,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        FD_VALID,
   input  logic [NUM_SRC*REG_AW-1:0]   SRC_F_D,
   input  logic [NUM_SRC-1:0]          SRC_VLD,
   input  logic [REG_AW-1:0]           DST_F_D,
   input  logic                        DST_VLD,
   input  logic [REG_AW-1:0]           D_E_DST,
   input  logic                        D_E_MEM_READ,
   input  logic                        CNT_CLR,
   output logic                        F_D_ENB,
   output logic                        PC_ENB,
   output logic                        FLUSH_LOAD_USE,
   output logic [CNT_W-1:0]            STALL_CNT,
   output logic [(2**REG_AW)-1:0]      PEND
);

   localparam int unsigned NumRegs = 2 ** REG_AW;
   localparam int unsigned PcW     = pend_cnt_w(LOAD_LAT);
   localparam logic [PcW-1:0] Reload = PcW'(LOAD_LAT - 1);
   localparam logic [CNT_W-1:0] CntMax = '1;

   logic [NumRegs-1:0] ld_sel;
   logic [NumRegs-1:0] pend_nz;
   logic [PcW-1:0]     pc_cnt [NumRegs];
   logic               src_hit;
   logic               dst_hit;
   logic               load_use;
   logic [CNT_W-1:0]   stall_cnt_d, stall_cnt_q;

   always_comb begin
      ld_sel = '0;
      if (D_E_MEM_READ) begin
         ld_sel[D_E_DST] = 1'b1;
      end
   end

   // A fresh load overrides the decrement, so a reload never loses a cycle.
   for (genvar g = 0; g < NumRegs; g++) begin : g_pend
      hdu_pend_ctr #(
         .W (PcW)
      ) u_pend_ctr (
         .clk_i     (clk),
         .rst_ni    (rst_n),
         .load_i    (ld_sel[g]),
         .dec_i     (~ld_sel[g]),
         .reload_i  (Reload),
         .count_o   (pc_cnt[g]),
         .nonzero_o (pend_nz[g])
      );
   end

   function automatic logic reg_hit(input logic [REG_AW-1:0] x);
      return (D_E_MEM_READ && (D_E_DST == x)) || (pc_cnt[x] != '0);
   endfunction

   always_comb begin
      src_hit = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (SRC_VLD[i] && reg_hit(`HDU_SRC(SRC_F_D, i, REG_AW))) begin
            src_hit = 1'b1;
         end
      end
      dst_hit  = DST_CHECK && DST_VLD && reg_hit(DST_F_D);
      load_use = rst_n && FD_VALID && (src_hit || dst_hit);
   end

   always_comb begin
      F_D_ENB        = ~load_use;
      PC_ENB         = ~load_use;
      FLUSH_LOAD_USE = load_use;
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (CNT_CLR) begin
         stall_cnt_d = '0;
      end else if (load_use && (stall_cnt_q != CntMax)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign STALL_CNT = stall_cnt_q;
   assign PEND      = pend_nz;

endmodule
